// File: rtl/pmp_mem_gate.sv
// pmp_mem_gate: drives pmp check lines per request, then forwards to the bus or returns an access/misaligned fault.
module pmp_mem_gate #(
  parameter int         CHECK_LAT  = 1,
  parameter logic [1:0] PERM_GRANT = 2'b01,
  parameter int         TIMEOUT    = 255,
  parameter logic [1:0] OPER_WRITE = 2'd1,
  parameter logic [1:0] OPER_EXEC  = 2'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_oper,
  input  logic [1:0]  req_priv,
  input  logic [31:0] req_wdata,
  output logic [31:0] pmp_addr,
  output logic [1:0]  pmp_size,
  output logic [1:0]  pmp_oper,
  output logic [1:0]  pmp_priv,
  input  logic [1:0]  pmp_permission,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause,
  output logic [31:0] rsp_tval
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0] CL_LAST = 8'(CHECK_LAT - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] wdata_q;
  logic        misaligned, is_wr;
  logic [3:0]  mis_cause, acc_cause;
  assign misaligned = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'd0);
  assign mis_cause  = req_oper == OPER_WRITE ? 4'd6 : req_oper == OPER_EXEC ? 4'd0 : 4'd4;
  assign is_wr      = pmp_oper == OPER_WRITE;
  assign acc_cause  = is_wr ? 4'd7 : pmp_oper == OPER_EXEC ? 4'd1 : 4'd5;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      pmp_addr  <= '0;
      pmp_size  <= '0;
      pmp_oper  <= '0;
      pmp_priv  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      rsp_cause <= '0;
      rsp_tval  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          if (misaligned) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_cause <= mis_cause;
            rsp_tval  <= req_addr;
          end else begin
            state    <= CHECK;
            cnt      <= '0;
            pmp_addr <= req_addr;
            pmp_size <= req_size;
            pmp_oper <= req_oper;
            pmp_priv <= req_priv;
            wdata_q  <= req_wdata;
          end
        end
        CHECK: if (cnt == CL_LAST) begin
          if (pmp_permission == PERM_GRANT) begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            mem_addr  <= pmp_addr;
            mem_we    <= is_wr;
            mem_size  <= pmp_size;
            mem_wdata <= wdata_q;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_cause <= acc_cause;
            rsp_tval  <= pmp_addr;
          end
        end else cnt <= cnt + 8'd1;
        ISSUE: if (mem_ready) begin
          state     <= WAIT;
          cnt       <= '0;
          mem_valid <= 1'b0;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_size  <= '0;
          mem_wdata <= '0;
        end
        // a completion arriving on the last allowed cycle still counts as success
        WAIT: if (mem_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= is_wr ? '0 : mem_rdata;
        end else if (cnt == TO_LAST) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b1;
          rsp_cause <= acc_cause;
          rsp_tval  <= pmp_addr;
        end else cnt <= cnt + 8'd1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_fault <= 1'b0;
          rsp_cause <= '0;
          rsp_tval  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmp_mem_gate.sv
// tb_pmp_mem_gate: directed table plus random transactions checked against a spec-level model.
module tb_pmp_mem_gate;
  localparam int CL = 1;
  localparam int TO = 255;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, EX = 2'd2;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic        req_valid = 0, req_ready;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0, req_oper = 0, req_priv = 0;
  logic [31:0] pmp_addr;
  logic [1:0]  pmp_size, pmp_oper, pmp_priv, pmp_permission = 0;
  logic        mem_valid, mem_ready = 0, mem_we, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [1:0]  mem_size;
  logic        rsp_valid, rsp_ready = 0, rsp_fault;
  logic [31:0] rsp_rdata, rsp_tval;
  logic [3:0]  rsp_cause;
  int tests = 0, fails = 0;
  pmp_mem_gate #(.CHECK_LAT(CL), .PERM_GRANT(GRANT), .TIMEOUT(TO), .OPER_WRITE(WR), .OPER_EXEC(EX)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_oper(req_oper), .req_priv(req_priv), .req_wdata(req_wdata),
    .pmp_addr(pmp_addr), .pmp_size(pmp_size), .pmp_oper(pmp_oper), .pmp_priv(pmp_priv),
    .pmp_permission(pmp_permission),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_cause(rsp_cause), .rsp_tval(rsp_tval)
  );
  typedef struct {
    logic [31:0] addr; logic [1:0] size, oper, priv; logic [31:0] wdata; logic [1:0] perm;
    int rdy; int rv; int hold; logic [31:0] rdata;
  } txn_t;
  typedef struct {
    bit fault; logic [3:0] cause; logic [31:0] tval, rdata; int lat; bit mem; bit pmp;
  } exp_t;
  typedef struct {
    txn_t t; bit fault; logic [3:0] cause; logic [31:0] tval, rdata;
  } vec_t;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic exp_t model(input txn_t t);
    exp_t e;
    bit mis;
    int kind;
    mis  = (t.size == 1 && t.addr % 2 != 0) || (t.size >= 2 && t.addr % 4 != 0);
    kind = t.oper == WR ? 1 : t.oper == EX ? 2 : 0;
    e = '{fault: 0, cause: 0, tval: 0, rdata: 0, lat: 0, mem: 0, pmp: !mis};
    if (mis) begin
      e.fault = 1; e.tval = t.addr; e.lat = 1;
      e.cause = kind == 1 ? 4'd6 : kind == 2 ? 4'd0 : 4'd4;
    end else if (t.perm != GRANT || t.rv < 0) begin
      e.fault = 1; e.tval = t.addr;
      e.cause = kind == 1 ? 4'd7 : kind == 2 ? 4'd1 : 4'd5;
      e.mem = t.perm == GRANT;
      e.lat = e.mem ? 2 + CL + t.rdy + TO : 1 + CL;
    end else begin
      e.mem = 1; e.rdata = kind == 1 ? 32'd0 : t.rdata; e.lat = 3 + CL + t.rdy + t.rv;
    end
    return e;
  endfunction
  task automatic do_reset();
    reset = 1; req_valid = 0; mem_ready = 0; mem_rvalid = 0; rsp_ready = 0;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask
  task automatic run_txn(input txn_t t, input exp_t e);
    int c, ic, wc, nmem;
    bit hs, done;
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = t.addr; req_size = t.size; req_oper = t.oper;
    req_priv = t.priv; req_wdata = t.wdata; pmp_permission = t.perm;
    @(negedge clock);
    req_valid = 0; c = 1; ic = 0; wc = 0; nmem = 0; hs = 0; done = 0;
    if (e.pmp) chk("pmp_lines", {pmp_addr[27:0], pmp_size, pmp_oper}, {t.addr[27:0], t.size, t.oper});
    if (e.pmp) chk("pmp_priv", pmp_priv, t.priv);
    while (!done && c < 2000) begin
      if (rsp_valid) done = 1;
      else begin
        if (mem_valid) begin
          nmem++;
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_ctl", {mem_we, mem_size}, {t.oper == WR, t.size});
          chk("mem_wdata", mem_wdata, t.wdata);
          mem_ready = ic == t.rdy;
          if (mem_ready) hs = 1;
          ic++;
        end else begin
          chk("mem_idle_zero", {mem_we, mem_size, mem_addr[28:0]}, 0);
          mem_ready = 0;
          if (hs) begin
            mem_rvalid = t.rv >= 0 && wc == t.rv;
            mem_rdata = mem_rvalid ? t.rdata : $urandom;
            wc++;
          end
        end
        @(negedge clock);
        c++;
      end
    end
    mem_ready = 0; mem_rvalid = 0;
    chk("rsp_arrived", done, 1);
    if (!done) do_reset();
    else begin
      chk("latency", c, e.lat);
      chk("mem_used", nmem > 0, e.mem);
      for (int h = 0; h <= t.hold; h++) begin
        chk("rsp_fault", rsp_fault, e.fault);
        chk("rsp_cause", rsp_cause, e.cause);
        chk("rsp_tval", rsp_tval, e.tval);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_hold_valid", {rsp_valid, req_ready}, 2'b10);
        if (h < t.hold) begin
          req_valid = 1; req_addr = $urandom;
          @(negedge clock);
        end
      end
      req_valid = 0; rsp_ready = 1;
      @(negedge clock);
      rsp_ready = 0;
      chk("back_idle", {rsp_valid, req_ready, mem_valid}, 3'b010);
      if (e.pmp) chk("pmp_held", pmp_addr, t.addr);
    end
  endtask
  vec_t vecs[9];
  initial begin
    exp_t e;
    txn_t t;
    vecs[0] = '{'{32'h1000, 2, RD, 2'd3, 32'h0, GRANT, 0, 0, 0, 32'hDEADBEEF}, 0, 4'd0, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{'{32'h2000, 2, WR, 2'd0, 32'h55, 2'b00, 0, 0, 0, 32'h0}, 1, 4'd7, 32'h2000, 32'h0};
    vecs[2] = '{'{32'h3001, 1, EX, 2'd3, 32'h0, GRANT, 0, 0, 0, 32'h0}, 1, 4'd0, 32'h3001, 32'h0};
    vecs[3] = '{'{32'h4000, 2, RD, 2'd1, 32'h0, GRANT, 5, -1, 0, 32'h0}, 1, 4'd5, 32'h4000, 32'h0};
    vecs[4] = '{'{32'h5004, 2, WR, 2'd1, 32'hA5A5A5A5, GRANT, 1, 2, 4, 32'h12345678}, 0, 4'd0, 32'h0, 32'h0};
    vecs[5] = '{'{32'h6002, 3, RD, 2'd0, 32'h0, GRANT, 0, 0, 0, 32'h0}, 1, 4'd4, 32'h6002, 32'h0};
    vecs[6] = '{'{32'h7003, 0, WR, 2'd0, 32'h77, GRANT, 0, 0, 1, 32'h0}, 0, 4'd0, 32'h0, 32'h0};
    vecs[7] = '{'{32'h8000, 2, EX, 2'd3, 32'h0, 2'b11, 0, 0, 0, 32'h0}, 1, 4'd1, 32'h8000, 32'h0};
    vecs[8] = '{'{32'h9001, 1, WR, 2'd0, 32'h0, GRANT, 0, 0, 0, 32'h0}, 1, 4'd6, 32'h9001, 32'h0};
    do_reset();
    chk("reset_state", {req_ready, rsp_valid, mem_valid, rsp_fault}, 4'b1000);
    chk("reset_pmp", pmp_addr, 0);
    foreach (vecs[i]) begin
      e = model(vecs[i].t);
      e.fault = vecs[i].fault; e.cause = vecs[i].cause; e.tval = vecs[i].tval; e.rdata = vecs[i].rdata;
      run_txn(vecs[i].t, e);
    end
    for (int i = 0; i < 40; i++) begin
      t.addr  = $urandom; t.size = 2'($urandom_range(0, 3)); t.oper = 2'($urandom_range(0, 3));
      t.priv  = 2'($urandom); t.wdata = $urandom; t.rdata = $urandom;
      t.perm  = $urandom_range(0, 9) < 7 ? GRANT : 2'($urandom_range(0, 3));
      t.rdy   = $urandom_range(0, 3);
      t.rv    = $urandom_range(0, 19) == 0 ? -1 : int'($urandom_range(0, 4));
      t.hold  = $urandom_range(0, 2);
      if (i % 3 == 0) t.addr[1:0] = 2'b00;
      run_txn(t, model(t));
    end
    @(negedge clock);
    req_valid = 1; req_addr = 32'hA000; req_size = 2; req_oper = RD; pmp_permission = GRANT;
    @(negedge clock);
    req_valid = 0;
    for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clock);
    chk("rst_seq_issue", mem_valid, 1);
    mem_ready = 1;
    @(negedge clock);
    mem_ready = 0;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rst_mid_wait", {req_ready, rsp_valid, mem_valid}, 3'b100);
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clock);
    mem_rvalid = 0;
    chk("late_rvalid_ignored", {req_ready, rsp_valid, mem_valid}, 3'b100);
    @(negedge clock);
    chk("late_rvalid_idle", {req_ready, rsp_valid, rsp_rdata[0]}, 3'b100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
